seq_detect_prog: RTL and testbench

SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

---
 rtl/seq_detect_prog.sv | 97 +++++++++
 tb/tb_seq_detect_prog.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: runtime-loadable pattern/length,
// overlapping or non-overlapping detection, saturating detection counter.
module seq_detect_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1011),
    parameter int                 DEF_LEN     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         seq_in,
    input  logic                         in_valid,
    input  logic                         overlap,
    input  logic                         cfg_load,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         clr_cnt,
    output logic                         det,
    output logic [CNT_W-1:0]             det_cnt,
    output logic                         cfg_err
);

    localparam int LW = $clog2(MAX_LEN + 1);

    // Only the len-1 bits preceding the incoming bit are ever compared,
    // so MAX_LEN-1 bits of history cover the longest pattern.
    logic [MAX_LEN-2:0] hist;
    logic [MAX_LEN-1:0] pattern;
    logic [LW-1:0]      len;
    logic [LW-1:0]      fill;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic [LW:0]        fill_p1;
    logic               len_ok;
    logic               sample;
    logic               match;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
        window  = {hist, seq_in};
        fill_p1 = {1'b0, fill} + {{LW{1'b0}}, 1'b1};
        len_ok  = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
        sample  = in_valid && !cfg_load;
        match   = (((window ^ pattern) & mask) == '0) && (fill_p1 >= {1'b0, len});
    end

    // NOTE: sequential state uses non-blocking assignments only, and the
    // history is reset along with everything else so a partial match
    // cannot survive a reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            det     <= 1'b0;
            cfg_err <= 1'b0;
            det_cnt <= '0;
            hist    <= '0;
            fill    <= '0;
            pattern <= DEF_PATTERN;
            len     <= LW'(DEF_LEN);
        end else begin
            det     <= sample && match;
            cfg_err <= cfg_load && !len_ok;

            // A load in the same cycle as a sample wins; the sample is dropped.
            if (cfg_load) begin
                if (len_ok) begin
                    pattern <= cfg_pattern;
                    len     <= cfg_len;
                    hist    <= '0;
                    fill    <= '0;
                end
            end else if (in_valid) begin
                if (match && !overlap) begin
                    hist <= '0;
                    fill <= '0;
                end else begin
                    hist <= window[MAX_LEN-2:0];
                    if (fill != LW'(MAX_LEN)) begin
                        fill <= fill + LW'(1);
                    end
                end
            end

            if (clr_cnt) begin
                det_cnt <= '0;
            end else if (sample && match && (det_cnt != '1)) begin
                det_cnt <= det_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: per-cycle scoreboard of expected
// det/cfg_err plus explicit detection-counter checks per scenario.
module tb_seq_detect_prog;

    typedef struct packed {
        logic det;
        logic err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       seq_in;
    logic       in_valid;
    logic       overlap;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       clr_cnt;

    logic       det, cfg_err;
    logic [7:0] det_cnt;
    logic       det2, cfg_err2;
    logic [1:0] det_cnt2;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    seq_detect_prog dut (
        .clk(clk), .rst(rst), .seq_in(seq_in), .in_valid(in_valid),
        .overlap(overlap), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .clr_cnt(clr_cnt),
        .det(det), .det_cnt(det_cnt), .cfg_err(cfg_err)
    );

    seq_detect_prog #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .seq_in(seq_in), .in_valid(in_valid),
        .overlap(overlap), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .clr_cnt(clr_cnt),
        .det(det2), .det_cnt(det_cnt2), .cfg_err(cfg_err2)
    );

    // One clock of stimulus; the expected outputs are queued with the
    // stimulus and popped once the registered outputs have updated.
    task automatic drive(input logic v, input logic b, input logic ld,
                         input logic [7:0] pat, input logic [3:0] ln,
                         input logic clr, input logic exp_det, input logic exp_err);
        exp_t e;
        seq_in      = b;
        in_valid    = v;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = ln;
        clr_cnt     = clr;
        sb.push_back('{det: exp_det, err: exp_err});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_checks++;
        if (det !== e.det) begin
            n_fail++;
            $display("FAIL det @%0t: got %b expected %b", $time, det, e.det);
        end
        n_checks++;
        if (det2 !== e.det) begin
            n_fail++;
            $display("FAIL det_sat @%0t: got %b expected %b", $time, det2, e.det);
        end
        n_checks++;
        if (cfg_err !== e.err) begin
            n_fail++;
            $display("FAIL cfg_err @%0t: got %b expected %b", $time, cfg_err, e.err);
        end
        in_valid = 1'b0;
        cfg_load = 1'b0;
        clr_cnt  = 1'b0;
    endtask

    // bits[n-1] is sent first; dets[k] is the expected det after bits[k].
    task automatic run_bits(input logic [31:0] bits, input int n, input logic [31:0] dets);
        for (int i = n - 1; i >= 0; i--) begin
            drive(1'b1, bits[i], 1'b0, '0, '0, 1'b0, dets[i], 1'b0);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        cfg_load = 1'b0;
        clr_cnt  = 1'b0;
        rst      = 1'b0;
        #10;
        rst      = 1'b1;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        seq_in      = 1'b1;
        in_valid    = 1'b1;
        overlap     = 1'b1;
        cfg_load    = 1'b1;
        cfg_pattern = 8'hFF;
        cfg_len     = 4'd0;
        clr_cnt     = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (det !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_det: got %b expected 0", det);
        end
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cfg_err: got %b expected 0", cfg_err);
        end
        n_checks++;
        if (det_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_det_cnt: got %0d expected 0", det_cnt);
        end
        in_valid = 1'b0;
        cfg_load = 1'b0;
        rst      = 1'b1;
        // The default pattern 1011 must be live straight out of reset.
        run_bits(32'b1011, 4, 32'b0001);
        n_checks++;
        if (det_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_default_cnt: got %0d expected 1", det_cnt);
        end
    endtask

    task automatic test_overlap_basic();
        do_reset();
        overlap = 1'b1;
        run_bits(32'b0101011, 7, 32'b0000001);
        n_checks++;
        if (det_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL basic_cnt: got %0d expected 1", det_cnt);
        end
    endtask

    task automatic test_overlap_mode();
        do_reset();
        overlap = 1'b1;
        run_bits(32'b1011011, 7, 32'b0001001);
        n_checks++;
        if (det_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL overlap_on_cnt: got %0d expected 2", det_cnt);
        end
        do_reset();
        overlap = 1'b0;
        run_bits(32'b1011011, 7, 32'b0001000);
        n_checks++;
        if (det_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL overlap_off_cnt: got %0d expected 1", det_cnt);
        end
    endtask

    task automatic test_load();
        do_reset();
        overlap = 1'b1;
        // Upper pattern bits are junk and must be ignored with len 3.
        drive(1'b0, 1'b0, 1'b1, 8'b1010_1110, 4'd3, 1'b0, 1'b0, 1'b0);
        run_bits(32'b110110, 6, 32'b001001);
        n_checks++;
        if (det_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL load_cnt: got %0d expected 2", det_cnt);
        end
        drive(1'b0, 1'b0, 1'b1, 8'hFF, 4'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 8'hFF, 4'd9, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'hFF, 4'd9, 1'b0, 1'b0, 1'b0);
        // History survived the rejected loads, so 110 completes on the third bit.
        run_bits(32'b110, 3, 32'b001);
        n_checks++;
        if (det_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL load_after_err_cnt: got %0d expected 3", det_cnt);
        end
        drive(1'b0, 1'b0, 1'b1, 8'b1100_1010, 4'd8, 1'b0, 1'b0, 1'b0);
        run_bits(32'b0_1100_1010, 9, 32'b0_0000_0001);
        drive(1'b0, 1'b0, 1'b1, 8'hFE, 4'd1, 1'b0, 1'b0, 1'b0);
        run_bits(32'b0010, 4, 32'b1101);
        overlap = 1'b0;
        run_bits(32'b0010, 4, 32'b1101);
        n_checks++;
        if (det_cnt !== 8'd10) begin
            n_fail++;
            $display("FAIL load_len_bounds_cnt: got %0d expected 10", det_cnt);
        end
    endtask

    task automatic test_invalid_default();
        do_reset();
        overlap = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
        run_bits(32'b1011, 4, 32'b0001);
        n_checks++;
        if (det_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL invalid_default_cnt: got %0d expected 1", det_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        overlap = 1'b1;
        run_bits(32'b1011_0110_1101_1011, 16, 32'b0001_0010_0100_1001);
        n_checks++;
        if (det_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL sat_cnt_wide: got %0d expected 5", det_cnt);
        end
        n_checks++;
        if (det_cnt2 !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_cnt_narrow: got %0d expected 3", det_cnt2);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (det_cnt2 !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d expected 3", det_cnt2);
        end
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (det_cnt !== 8'd0 || det_cnt2 !== 2'd0) begin
            n_fail++;
            $display("FAIL clr_vs_det: got %0d/%0d expected 0/0", det_cnt, det_cnt2);
        end
        run_bits(32'b011, 3, 32'b001);
        n_checks++;
        if (det_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL count_after_clr: got %0d expected 1", det_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        overlap = 1'b1;
        run_bits(32'b101, 3, 32'b000);
        rst = 1'b0;
        #10;
        n_checks++;
        if (det !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_det: got %b expected 0", det);
        end
        rst = 1'b1;
        run_bits(32'b1, 1, 32'b0);
        run_bits(32'b1011, 4, 32'b0001);
        n_checks++;
        if (det_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL mid_reset_cnt: got %0d expected 1", det_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        overlap = 1'b1;
        run_bits(32'b101, 3, 32'b000);
        // Load coincides with the completing bit: the sample is discarded.
        drive(1'b1, 1'b1, 1'b1, 8'h0B, 4'd4, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (det_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL gapped_cnt: got %0d expected 1", det_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_overlap_basic();
        test_overlap_mode();
        test_load();
        test_invalid_default();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
